// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmit and keyboard receive paths:
// FSM encodings, frame length, line drive polarity and frame helpers.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_SEND      = 3'd2,
    ST_ACK       = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  // Bits driven by the host after the start bit: 8 data, parity, stop.
  localparam int PS2_FRAME_BITS = 10;

  // Open-drain lines: a drive-low enable of 1 pulls the pin low, 0 lets the pull-up win.
  localparam logic DRIVE_LOW = 1'b1;
  localparam logic RELEASE   = 1'b0;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input logic par, input logic [3:0] idx);
    if (idx < 4'd8)
      return d[idx[2:0]];
    else if (idx == 4'd8)
      return par;
    else
      return 1'b1;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status handshake between the controlling FSM and the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output tx_data, tx_start,
    input  busy, done, ack_err, timeout
  );

  modport slave (
    input  tx_data, tx_start,
    output busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronized clock. Shared by the host transmit and receive paths.
module ps2_sync_edge (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] pin_in;
  logic [1:0] pin_sync;
  logic       clk_prev_reg;

  assign pin_in = {ps2_data_in, ps2_clk_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Reset to the idle-high line level so leaving reset never fakes an edge.
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pin_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pin_sync[gi] = sync_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      clk_prev_reg <= 1'b1;
    else
      clk_prev_reg <= pin_sync[0];
  end

  assign clk_sync  = pin_sync[0];
  assign data_sync = pin_sync[1];
  assign clk_fall  = clk_prev_reg & ~pin_sync[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one byte with odd
// parity on device clock falling edges, checks the device ACK, with a frame timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic            clk,
  input  logic            clrn,
  ps2_host_tx_if.slave    ctl,
  input  logic            ps2_clk_in,
  input  logic            ps2_data_in,
  output logic            ps2_clk_drive_low,
  output logic            ps2_data_drive_low
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       STOP_IDX = 4'(PS2_FRAME_BITS - 1);

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall   (clk_fall)
  );

  state_t           state_reg,   state_next;
  logic [7:0]       data_reg,    data_next;
  logic             par_reg,     par_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic [TO_W-1:0]  to_cnt_reg,  to_cnt_next;
  logic [3:0]       bit_idx_reg, bit_idx_next;
  logic             clk_dl_reg,  clk_dl_next;
  logic             data_dl_reg, data_dl_next;
  logic             ack_err_reg, ack_err_next;
  logic             done_reg,    done_next;
  logic             timeout_reg, timeout_next;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg   <= ST_IDLE;
      data_reg    <= '0;
      par_reg     <= 1'b0;
      inh_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      bit_idx_reg <= '0;
      clk_dl_reg  <= RELEASE;
      data_dl_reg <= RELEASE;
      ack_err_reg <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      par_reg     <= par_next;
      inh_cnt_reg <= inh_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      bit_idx_reg <= bit_idx_next;
      clk_dl_reg  <= clk_dl_next;
      data_dl_reg <= data_dl_next;
      ack_err_reg <= ack_err_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    par_next     = par_reg;
    inh_cnt_next = inh_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    bit_idx_next = bit_idx_reg;
    clk_dl_next  = clk_dl_reg;
    data_dl_next = data_dl_reg;
    ack_err_next = ack_err_reg;
    done_next    = 1'b0;
    timeout_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (ctl.tx_start) begin
          data_next    = ctl.tx_data;
          par_next     = odd_parity(ctl.tx_data);
          ack_err_next = 1'b0;
          inh_cnt_next = '0;
          clk_dl_next  = DRIVE_LOW;
          data_dl_next = (INHIBIT_CYCLES == 1) ? DRIVE_LOW : RELEASE;
          state_next   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        inh_cnt_next = inh_cnt_reg + 1'b1;
        if (inh_cnt_reg == INH_LAST) begin
          clk_dl_next  = RELEASE;
          to_cnt_next  = '0;
          bit_idx_next = '0;
          state_next   = ST_SEND;
        end else if (inh_cnt_reg == INH_PRE) begin
          // Start bit goes out during the final inhibit cycle.
          data_dl_next = DRIVE_LOW;
        end
      end

      ST_SEND, ST_ACK: begin
        to_cnt_next = to_cnt_reg + 1'b1;
        if (to_cnt_reg == TO_LAST) begin
          clk_dl_next  = RELEASE;
          data_dl_next = RELEASE;
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else if (clk_fall) begin
          if (state_reg == ST_SEND) begin
            data_dl_next = ~frame_bit(data_reg, par_reg, bit_idx_reg);
            bit_idx_next = bit_idx_reg + 1'b1;
            if (bit_idx_reg == STOP_IDX)
              state_next = ST_ACK;
          end else begin
            ack_err_next = data_sync;
            state_next   = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign ctl.busy           = (state_reg != ST_IDLE);
  assign ctl.done           = done_reg;
  assign ctl.ack_err        = done_reg & ack_err_reg;
  assign ctl.timeout        = timeout_reg;
  assign ps2_clk_drive_low  = clk_dl_reg;
  assign ps2_data_drive_low = data_dl_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard model, a
// scoreboard queue of expected outcomes and a monitor that checks each done/timeout.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 1000;
  localparam int HALF = 20;

  typedef struct {
    bit         is_to;
    bit         ack_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic clrn;
  logic ps2_clk_drive_low;
  logic ps2_data_drive_low;
  logic dev_clk_low;
  logic dev_data_low;
  logic line_clk;
  logic line_data;

  ps2_host_tx_if ctl ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk               (clk),
    .clrn              (clrn),
    .ctl               (ctl),
    .ps2_clk_in        (line_clk),
    .ps2_data_in       (line_data),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low)
  );

  assign line_clk  = ~(ps2_clk_drive_low | dev_clk_low);
  assign line_data = ~(ps2_data_drive_low | dev_data_low);

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   send_entry_cyc = 0;
  int   mon_events = 0;
  exp_t sb_q[$];

  bit          dev_clocks = 1;
  bit          dev_ack = 1;
  bit          dev_busy = 0;
  bit          dev_abort = 0;
  int          dev_bits_rcvd = 0;
  logic [10:0] rx_frame = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog act=still_running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int v;
    int ones;
    v = int'(b);
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((v >> i) % 2) == 1;
      ones += (v >> i) % 2;
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- keyboard model ----------------
  task automatic dev_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!clrn) dev_abort = 1;
    end
  endtask

  task automatic dev_frame();
    logic [10:0] bits;
    bits = '0;
    dev_bits_rcvd = 0;
    dev_wait(HALF);
    if (dev_abort) return;
    bits[0] = line_data;
    dev_bits_rcvd = 1;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      dev_wait(HALF);
      if (dev_abort) return;
      bits[i] = line_data;
      dev_bits_rcvd = i + 1;
      dev_clk_low = 1'b0;
      dev_wait(HALF);
      if (dev_abort) return;
    end
    rx_frame = bits;
    if (dev_ack) dev_data_low = 1'b1;
    dev_wait(5);
    if (dev_abort) return;
    dev_clk_low = 1'b1;
    dev_wait(HALF);
    if (dev_abort) return;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    dev_wait(2);
  endtask

  initial begin
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    forever begin
      @(negedge clk);
      if (clrn && dev_clocks && line_clk && !line_data) begin
        dev_busy  = 1;
        dev_abort = 0;
        dev_frame();
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        dev_busy  = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int   inh_run;
    exp_t e;
    inh_run = 0;
    forever begin
      @(negedge clk);
      if (!clrn) begin
        inh_run = 0;
      end else begin
        if (ps2_clk_drive_low) begin
          inh_run++;
        end else if (inh_run != 0) begin
          chk("inhibit_len", inh_run, INH);
          send_entry_cyc = cyc;
          inh_run = 0;
        end
        if (ctl.done || ctl.timeout) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event act=done%0d_timeout%0d req=none", ctl.done, ctl.timeout);
          end else begin
            e = sb_q.pop_front();
            chk("event_kind_timeout", ctl.timeout, e.is_to);
            chk("event_kind_done", ctl.done, !e.is_to);
            chk("busy_at_end", ctl.busy, 0);
            if (e.is_to) begin
              chk("to_clk_release", ps2_clk_drive_low, 0);
              chk("to_data_release", ps2_data_drive_low, 0);
              chk("to_delay", cyc - send_entry_cyc, TO);
            end else begin
              chk("ack_err", ctl.ack_err, e.ack_err);
              chk("rx_frame", rx_frame, model_frame(e.data));
            end
            $display("txn data=%02h timeout=%0d done=%0d ack_err=%0d rx_frame=%03h",
                     e.data, ctl.timeout, ctl.done, ctl.ack_err, rx_frame);
          end
          mon_events++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    ctl.tx_data  = b;
    ctl.tx_start = 1'b1;
    @(negedge clk);
    ctl.tx_start = 1'b0;
    ctl.tx_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send(input logic [7:0] b, input bit ack, input bit exp_to);
    exp_t e;
    e.is_to   = exp_to;
    e.ack_err = !ack;
    e.data    = b;
    dev_ack = ack;
    dev_bits_rcvd = 0;
    sb_q.push_back(e);
    pulse_start(b);
  endtask

  task automatic wait_bits(input int nbits);
    int n;
    n = 0;
    while (dev_bits_rcvd < nbits && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bits_bound", n < 3000, 1);
  endtask

  task automatic stray_start();
    wait_bits(3);
    pulse_start(8'h55);
  endtask

  task automatic wait_all();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || dev_busy || ctl.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("completion_bound", n < 3000, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int          n;
    exp_t        e;
    logic [7:0]  rb;
    bit          rack;

    clrn         = 1'b0;
    ctl.tx_start = 1'b0;
    ctl.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", ctl.busy, 0);
    chk("rst_done", ctl.done, 0);
    chk("rst_ack_err", ctl.ack_err, 0);
    chk("rst_timeout", ctl.timeout, 0);
    chk("rst_clk_dl", ps2_clk_drive_low, 0);
    chk("rst_data_dl", ps2_data_drive_low, 0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    // Basic byte, then the parity sweep.
    send(8'hED, 1, 0);
    wait_all();
    send(8'h00, 1, 0);
    wait_all();
    send(8'h01, 1, 0);
    wait_all();
    send(8'hFF, 1, 0);
    wait_all();

    // Device withholds ACK.
    send(8'hF4, 0, 0);
    wait_all();

    // Device never clocks: frame must time out.
    dev_clocks = 0;
    send(8'hA5, 1, 1);
    wait_all();
    dev_clocks = 1;
    repeat (5) @(negedge clk);

    // tx_start during SEND is ignored.
    send(8'hED, 1, 0);
    stray_start();
    wait_all();

    // Back-to-back start in the done cycle.
    send(8'h12, 1, 0);
    n = 0;
    while (!ctl.done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_bound", n < 3000, 1);
    e.is_to   = 0;
    e.ack_err = 0;
    e.data    = 8'h34;
    sb_q.push_back(e);
    ctl.tx_data  = 8'h34;
    ctl.tx_start = 1'b1;
    @(negedge clk);
    ctl.tx_start = 1'b0;
    chk("b2b_busy", ctl.busy, 1);
    chk("b2b_inhibit", ps2_clk_drive_low, 1);
    wait_all();

    // Asynchronous reset after the 4th data bit, then a clean 0xFF.
    dev_ack = 1;
    dev_bits_rcvd = 0;
    pulse_start(8'hAB);
    wait_bits(5);
    #2;
    clrn = 1'b0;
    #1;
    chk("arst_clk_dl", ps2_clk_drive_low, 0);
    chk("arst_data_dl", ps2_data_drive_low, 0);
    chk("arst_busy", ctl.busy, 0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    wait_all();
    send(8'hFF, 1, 0);
    wait_all();

    // Randomized bytes, ACK behaviour and stray starts.
    for (int i = 0; i < 8; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      send(rb, rack, 0);
      if ($urandom_range(0, 1) == 1) stray_start();
      wait_all();
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
